// File: rtl/sram_resp_pkg.sv
// Shared constants and FSM state encoding for the SRAM device-side responder.
package sram_resp_pkg;

    localparam int unsigned DEPTH_W_DEF = 10;
    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned ADDR_W      = 20;
    localparam int unsigned DATA_W      = 16;

    typedef enum logic [0:0] {
        ST_INIT,
        ST_READY
    } state_e;

endpackage

// File: rtl/sram_resp_array.sv
// Byte-lane-writable word array: one asynchronous read port, one clocked write port.
module sram_resp_array
    import sram_resp_pkg::*;
#(
    parameter int unsigned DEPTH_W = DEPTH_W_DEF
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [1:0]        i_be,
    input  logic [DEPTH_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DEPTH_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned WORDS = 1 << DEPTH_W;

    logic [DATA_W-1:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            if (i_be[0]) r_mem[i_waddr][7:0]  <= i_wdata[7:0];
            if (i_be[1]) r_mem[i_waddr][15:8] <= i_wdata[15:8];
        end
    end

    // Read sees pre-edge contents, so a same-cycle write is visible only next cycle.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sram_resp.sv
// Device end of a 16-bit async SRAM bus: clears the array after reset, then serves
// combinational reads and clocked byte-lane writes with access counters and a contention flag.
module sram_resp
    import sram_resp_pkg::*;
#(
    parameter int unsigned DEPTH_W = DEPTH_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sram_ce_n,
    input  logic              sram_we_n,
    input  logic              sram_oe_n,
    input  logic              sram_ub_n,
    input  logic              sram_lb_n,
    input  logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_wr_data,
    output logic [DATA_W-1:0] sram_rd_data,
    output logic              init_done,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count,
    output logic              err_contention
);

    state_e             r_state;
    logic [DEPTH_W-1:0] r_idx;
    logic               r_init_done;
    logic [CNT_W-1:0]   r_wr_count;
    logic [CNT_W-1:0]   r_rd_count;
    logic               r_err;

    logic               w_sel;
    logic               w_wr;
    logic               w_rd;
    logic               w_cont;
    logic               w_sweep;
    logic               w_arr_we;
    logic [1:0]         w_arr_be;
    logic [DEPTH_W-1:0] w_arr_waddr;
    logic [DATA_W-1:0]  w_arr_wdata;
    logic [DATA_W-1:0]  w_arr_rdata;
    logic               w_unused_addr;

    // Upper address bits are deliberately ignored: the array aliases modulo 2^DEPTH_W.
    assign w_unused_addr = ^sram_addr[ADDR_W-1:DEPTH_W];

    assign w_sel   = ~sram_ce_n & r_init_done;
    assign w_wr    = w_sel & ~sram_we_n;
    assign w_rd    = w_sel & ~sram_oe_n & sram_we_n;
    assign w_cont  = w_sel & ~sram_we_n & ~sram_oe_n;
    assign w_sweep = (r_state == ST_INIT);

    assign w_arr_we    = w_sweep | w_wr;
    assign w_arr_be    = w_sweep ? 2'b11 : {~sram_ub_n, ~sram_lb_n};
    assign w_arr_waddr = w_sweep ? r_idx : sram_addr[DEPTH_W-1:0];
    assign w_arr_wdata = w_sweep ? '0 : sram_wr_data;

    sram_resp_array #(
        .DEPTH_W (DEPTH_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_be    (w_arr_be),
        .i_waddr (w_arr_waddr),
        .i_wdata (w_arr_wdata),
        .i_raddr (sram_addr[DEPTH_W-1:0]),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_idx       <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_idx <= r_idx + DEPTH_W'(1);
                    if (r_idx == '1) begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end
                end
                ST_READY: r_init_done <= 1'b1;
                default:  r_state     <= ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_count <= '0;
            r_rd_count <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_wr && (r_wr_count != '1)) r_wr_count <= r_wr_count + CNT_W'(1);
            if (w_rd && (r_rd_count != '1)) r_rd_count <= r_rd_count + CNT_W'(1);
            if (w_cont)                     r_err      <= 1'b1;
        end
    end

    assign sram_rd_data   = w_rd ? {sram_ub_n ? 8'h00 : w_arr_rdata[15:8],
                                    sram_lb_n ? 8'h00 : w_arr_rdata[7:0]} : '0;
    assign init_done      = r_init_done;
    assign wr_count       = r_wr_count;
    assign rd_count       = r_rd_count;
    assign err_contention = r_err;

endmodule

// File: tb/tb_sram_resp.sv
// Directed bench for sram_resp (DEPTH_W=4): reference memory model plus read scoreboard.
module tb_sram_resp;

    logic        clk;
    logic        rst_n;
    logic        sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;
    logic [19:0] sram_addr;
    logic [15:0] sram_wr_data;
    logic [15:0] sram_rd_data;
    logic        init_done;
    logic [15:0] wr_count, rd_count;
    logic        err_contention;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    logic [15:0] ref_mem [16];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_wr   = 0;
    int          exp_rd   = 0;

    sram_resp #(
        .DEPTH_W (4),
        .CNT_W   (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sram_ce_n      (sram_ce_n),
        .sram_we_n      (sram_we_n),
        .sram_oe_n      (sram_oe_n),
        .sram_ub_n      (sram_ub_n),
        .sram_lb_n      (sram_lb_n),
        .sram_addr      (sram_addr),
        .sram_wr_data   (sram_wr_data),
        .sram_rd_data   (sram_rd_data),
        .init_done      (init_done),
        .wr_count       (wr_count),
        .rd_count       (rd_count),
        .err_contention (err_contention)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle();
        sram_ce_n = 1'b1; sram_we_n = 1'b1; sram_oe_n = 1'b1;
        sram_ub_n = 1'b0; sram_lb_n = 1'b0;
    endtask

    // Counts edges after release until init_done; bounded so a stuck sweep still ends.
    task automatic wait_init(input string tag);
        int cnt;
        cnt = 0;
        while (!init_done && cnt < 64) begin
            @(posedge clk); #1;
            cnt++;
        end
        idle();
        check(tag, 32'(cnt), 32'd16);
    endtask

    task automatic write_word(input logic [19:0] addr, input logic [15:0] data,
                              input logic ub, input logic lb);
        sram_addr = addr; sram_wr_data = data;
        sram_ub_n = ub; sram_lb_n = lb;
        sram_ce_n = 1'b0; sram_we_n = 1'b0; sram_oe_n = 1'b1;
        @(posedge clk); #1;
        if (!ub) ref_mem[addr[3:0]][15:8] = data[15:8];
        if (!lb) ref_mem[addr[3:0]][7:0]  = data[7:0];
        exp_wr++;
        idle();
    endtask

    task automatic read_word(input logic [19:0] addr, input logic ub, input logic lb,
                             input string tag);
        sb_t         e;
        logic [15:0] w;
        w     = ref_mem[addr[3:0]];
        e.tag = tag;
        e.exp = {ub ? 8'h00 : w[15:8], lb ? 8'h00 : w[7:0]};
        sram_addr = addr; sram_ub_n = ub; sram_lb_n = lb;
        sram_ce_n = 1'b0; sram_oe_n = 1'b0; sram_we_n = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        check(e.tag, {16'h0, sram_rd_data}, {16'h0, e.exp});
        @(posedge clk); #1;
        exp_rd++;
        idle();
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_wr"}, 32'(wr_count), 32'(exp_wr));
        check({tag, "_rd"}, 32'(rd_count), 32'(exp_rd));
    endtask

    initial begin
        logic [31:0] word32;
        logic [15:0] lo, hi;

        rst_n = 1'b0;
        idle();
        sram_addr = '0; sram_wr_data = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
        #23;
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        check("rst_err", 32'(err_contention), 32'd0);
        check("rst_rd_data", 32'(sram_rd_data), 32'd0);

        // Writes held active through the sweep must be ignored and not counted.
        @(negedge clk);
        rst_n = 1'b1;
        sram_addr = 20'h0; sram_wr_data = 16'hFFFF;
        sram_ce_n = 1'b0; sram_we_n = 1'b0;
        wait_init("init_latency");
        check_counts("init_writes_ignored");

        for (int a = 0; a < 16; a++) read_word(20'(a), 1'b0, 1'b0, $sformatf("clear_%0d", a));
        check_counts("after_clear");

        write_word(20'h3, 16'hA55A, 1'b0, 1'b1);
        read_word(20'h3, 1'b0, 1'b0, "upper_lane_only");
        read_word(20'h3, 1'b1, 1'b0, "rd_lane_masked");
        check_counts("lane_write");

        write_word(20'h00005, 16'h1234, 1'b0, 1'b0);
        read_word(20'h00015, 1'b0, 1'b0, "alias_0x15");
        read_word(20'hF0005, 1'b0, 1'b0, "alias_high_bits");

        // Contention: write proceeds, read data held at zero, flag set on the edge.
        sram_addr = 20'h2; sram_wr_data = 16'hBEEF;
        sram_ce_n = 1'b0; sram_we_n = 1'b0; sram_oe_n = 1'b0;
        @(negedge clk);
        check("cont_rd_zero", 32'(sram_rd_data), 32'd0);
        check("cont_err_before_edge", 32'(err_contention), 32'd0);
        @(posedge clk); #1;
        ref_mem[2] = 16'hBEEF;
        exp_wr++;
        idle();
        check("cont_err_set", 32'(err_contention), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("cont_err_sticky", 32'(err_contention), 32'd1);
        read_word(20'h2, 1'b0, 1'b0, "cont_write_landed");
        check_counts("after_cont");

        // ce_n high suppresses everything, even with all strobes low.
        sram_ce_n = 1'b1; sram_we_n = 1'b0; sram_oe_n = 1'b0;
        sram_addr = 20'h7; sram_wr_data = 16'h5555;
        @(negedge clk);
        check("ce_off_rd_zero", 32'(sram_rd_data), 32'd0);
        @(posedge clk); #1;
        idle();
        read_word(20'h7, 1'b0, 1'b0, "ce_off_no_write");
        check_counts("ce_off");

        word32 = 32'hDEAD_C0DE;
        write_word(20'h8, word32[15:0], 1'b0, 1'b0);
        write_word(20'h9, word32[31:16], 1'b0, 1'b0);
        sram_addr = 20'h8; sram_ce_n = 1'b0; sram_oe_n = 1'b0;
        @(negedge clk); lo = sram_rd_data;
        @(posedge clk); #1; exp_rd++;
        sram_addr = 20'h9;
        @(negedge clk); hi = sram_rd_data;
        @(posedge clk); #1; exp_rd++;
        idle();
        check("word32_pair", {hi, lo}, word32);
        check_counts("word32");

        // Reset mid-sweep: outputs clear at once and the sweep restarts from zero.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst1_err", 32'(err_contention), 32'd0);
        check("rst1_init_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_wr = 0; exp_rd = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
        check("mid_sweep_init_done", 32'(init_done), 32'd0);
        check("mid_sweep_rd_data", 32'(sram_rd_data), 32'd0);
        check_counts("mid_sweep");
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("resweep_latency");
        read_word(20'h2, 1'b0, 1'b0, "resweep_cleared_2");
        read_word(20'hF, 1'b0, 1'b0, "resweep_cleared_f");
        check_counts("resweep");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_resp.md
SRAM_RESP -- requirements
Module: sram_resp

Interface
REQ-001 Parameter: DEPTH_W, default 10; log2 of modelled 16-bit word count.
REQ-002 Parameter: CNT_W, default 16; width of the access counters.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sram_ce_n  input  1  chip enable, active-low.
REQ-006 sram_we_n  input  1  write enable, active-low.
REQ-007 sram_oe_n  input  1  output enable, active-low.
REQ-008 sram_ub_n  input  1  upper byte lane [15:8] enable, active-low.
REQ-009 sram_lb_n  input  1  lower byte lane [7:0] enable, active-low.
REQ-010 sram_addr  input  20  word address.
REQ-011 sram_wr_data  input  16  write data from the controller.
REQ-012 sram_rd_data  output  16  read data to the controller.
REQ-013 init_done  output  1  high once the array clear has completed.
REQ-014 wr_count  output  CNT_W  number of accepted write cycles, saturating.
REQ-015 rd_count  output  CNT_W  number of read-access cycles, saturating.
REQ-016 err_contention  output  1  sticky flag for an illegal access combination.

Function
REQ-017 The block SHALL act as the device end of the 16-bit asynchronous SRAM bus: combinational read, clocked write.
REQ-018 Only sram_addr[DEPTH_W-1:0] SHALL index the array; higher bits are ignored, so addresses alias modulo 2^DEPTH_W.
REQ-019 FSM states: ST_INIT, ST_READY; ST_INIT entered on reset.
REQ-020 In ST_INIT an index counter SHALL write 16'h0000 to one word per cycle, starting at 0; after word 2^DEPTH_W-1 the FSM SHALL move to ST_READY, so init_done rises exactly 2^DEPTH_W cycles after reset release.
REQ-021 ST_READY has no exit except reset.
REQ-022 Read access = ce_n=0, oe_n=0, we_n=1, init_done=1; sram_rd_data SHALL equal the addressed word in the same cycle, zero-latency, with a disabled byte lane reading as 8'h00.
REQ-023 When no read access is active, sram_rd_data SHALL be 16'h0000.
REQ-024 Write access = ce_n=0, we_n=0, init_done=1; on the clock edge each enabled byte lane of the addressed word SHALL take the corresponding byte of sram_wr_data; disabled lanes SHALL be unchanged.
REQ-025 Writes in ST_INIT SHALL be ignored and not counted.
REQ-026 A read of a word in the cycle it is being written SHALL return the old contents; the new value is visible from the next cycle.
REQ-027 Each write-access cycle SHALL increment wr_count by 1; each read-access cycle SHALL increment rd_count by 1; both saturate at all-ones.
REQ-028 Contention = ce_n=0, we_n=0, oe_n=0 with init_done=1; it SHALL set err_contention on the next edge until reset, while the write still proceeds, wr_count still increments, and sram_rd_data stays 16'h0000.
REQ-029 ce_n=1 SHALL suppress all access, counting and error detection regardless of the other strobes.

Reset
REQ-030 On rst_n low, regardless of state: FSM to ST_INIT, index counter 0, init_done 0, wr_count 0, rd_count 0, err_contention 0.
REQ-031 Array contents are undefined at reset assertion and are zeroed by the ST_INIT sweep after release; reset in mid-sweep SHALL restart the sweep from index 0.

Structure
REQ-032 Package sram_resp_pkg SHALL hold the state encoding and the default DEPTH_W/CNT_W constants.
REQ-033 Sub-module sram_resp_array SHALL hold the byte-lane-writable array with one asynchronous read port and one synchronous write port; the FSM, counters and error logic stay in sram_resp.

Verification
REQ-034 Reset release with DEPTH_W=4 -> init_done rises after exactly 16 cycles; a read of every address returns 16'h0000.
REQ-035 Write 16'hA55A at addr 3 with ub_n=0, lb_n=1, then read addr 3 -> 16'hA500; wr_count=1, rd_count=1.
REQ-036 Write 16'h1234 at addr 20'h00005, then read addr 20'h00015 (DEPTH_W=4) -> 16'h1234 via aliasing.
REQ-037 Drive ce_n=0, we_n=0, oe_n=0 at addr 2 with data 16'hBEEF -> err_contention=1 from next cycle and stays; a later normal read of addr 2 returns 16'hBEEF.
REQ-038 Assert rst_n low at cycle 7 of the sweep -> outputs and counters zero immediately; init_done rises 2^DEPTH_W cycles after release.
REQ-039 Run a 32-bit controller-style write/read pair (two 16-bit halves at addr and addr+1) -> both halves read back intact; writes issued during ST_INIT are ignored and not counted.
